sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
//   Shares one SDRAM command bus between a read engine and a write engine and
//   owns the periodic auto-refresh schedule.
//
//   Handshake: a side raises req to ask for the bus; the arbiter answers with
//   en=1 from the cycle after req is sampled and keeps en=1 for the whole
//   grant. After en drops the bus stays muxed to that engine until its
//   ready=1 is sampled (engine idle), only then can the next grant or refresh
//   start. rd_en and wr_en are never 1 together.
//
//   Optional feature macro: SDRAM_ARB_WR_PRIORITY_EN -- when defined, write
//   wins every tie and the grant quantum only limits read grants. Undefined
//   (default): round-robin tie break, quantum applies to both sides.
//
// Ports
//   clk, rst            clock, synchronous active-low reset
//   init_done           SDRAM init complete (gates refresh counter and grants)
//   rd_req / wr_req     service requests from the engines
//   rd_en / wr_en       registered grant enables to the engines
//   rd_ready / wr_ready engine idle indications
//   rd_/wr_command,addr,bank  engine command buses
//   command, addr, bank SDRAM command bus
//   auto_refresh        one-cycle refresh request to the granted engine
//   refresh_err         sticky flag: a refresh came due while one was pending
//   state_dbg           current FSM state (debug)
// ---------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int REFRESH_PERIOD = 781,
    parameter int T_RFC          = 7,
    parameter int GRANT_QUANTUM  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        rd_req,
    input  logic        wr_req,
    output logic        rd_en,
    output logic        wr_en,
    input  logic        rd_ready,
    input  logic        wr_ready,
    input  logic [2:0]  rd_command,
    input  logic [2:0]  wr_command,
    input  logic [11:0] rd_addr,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  rd_bank,
    input  logic [1:0]  wr_bank,
    output logic [2:0]  command,
    output logic [11:0] addr,
    output logic [1:0]  bank,
    output logic        auto_refresh,
    output logic        refresh_err,
    output logic [2:0]  state_dbg
);

    // SDRAM command encodings {ras_n, cas_n, we_n}
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_AR  = 3'b001;

    localparam int CW = $clog2(REFRESH_PERIOD + 1);
    localparam int TW = $clog2(T_RFC + 1);
    localparam int QW = $clog2(GRANT_QUANTUM + 1);

`ifdef SDRAM_ARB_WR_PRIORITY_EN
    localparam bit RD_QUANTUM = 1'b1;
    localparam bit WR_QUANTUM = 1'b0;
`else
    localparam bit RD_QUANTUM = 1'b1;
    localparam bit WR_QUANTUM = 1'b1;
`endif

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        REFRESH      = 3'd1,
        REFRESH_WAIT = 3'd2,
        GRANT_RD     = 3'd3,
        GRANT_WR     = 3'd4,
        RELEASE      = 3'd5
    } state_t;

    state_t          state;
    logic [CW-1:0]   ref_cnt;
    logic [TW-1:0]   wait_cnt;
    logic [QW-1:0]   q_cnt;
    logic            pending;
    logic            last_wr;   // 1: most recent grant went to write

    logic expire;
    logic quantum_up;
    logic pick_rd;
    logic rd_end;
    logic wr_end;

    assign expire     = init_done && (ref_cnt == '0);
    assign quantum_up = (q_cnt >= QW'(GRANT_QUANTUM - 1));
    assign rd_end     = !rd_req || (RD_QUANTUM && quantum_up && wr_req);
    assign wr_end     = !wr_req || (WR_QUANTUM && quantum_up && rd_req);
    assign state_dbg  = state;

`ifdef SDRAM_ARB_WR_PRIORITY_EN
    assign pick_rd = rd_req && !wr_req;
`else
    // Tie goes to the side that was not granted last.
    assign pick_rd = rd_req && (!wr_req || last_wr);
`endif

    // Refresh interval counter, frozen until the SDRAM is initialised.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_cnt <= CW'(REFRESH_PERIOD - 1);
        end else if (init_done) begin
            ref_cnt <= expire ? CW'(REFRESH_PERIOD - 1) : ref_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            rd_en        <= 1'b0;
            wr_en        <= 1'b0;
            auto_refresh <= 1'b0;
            refresh_err  <= 1'b0;
            pending      <= 1'b0;
            last_wr      <= 1'b1;
            q_cnt        <= '0;
            wait_cnt     <= '0;
        end else begin
            auto_refresh <= 1'b0;
            if (expire && pending)
                refresh_err <= 1'b1;
            // A refresh that comes due where it cannot be served right away
            // is remembered; IDLE and an ongoing grant override this below.
            if (expire)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (expire || pending) begin
                        state   <= REFRESH;
                        pending <= 1'b0;
                    end else if (init_done && (rd_req || wr_req)) begin
                        q_cnt <= '0;
                        if (pick_rd) begin
                            state   <= GRANT_RD;
                            rd_en   <= 1'b1;
                            last_wr <= 1'b0;
                        end else begin
                            state   <= GRANT_WR;
                            wr_en   <= 1'b1;
                            last_wr <= 1'b1;
                        end
                    end
                end
                REFRESH: begin
                    state    <= REFRESH_WAIT;
                    wait_cnt <= TW'(T_RFC - 1);
                end
                REFRESH_WAIT: begin
                    if (wait_cnt == '0)
                        state <= IDLE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                GRANT_RD, GRANT_WR: begin
                    if ((state == GRANT_RD) ? rd_end : wr_end) begin
                        state <= RELEASE;
                        rd_en <= 1'b0;
                        wr_en <= 1'b0;
                    end else begin
                        // Engine keeps the bus and runs the refresh itself.
                        if (expire) begin
                            auto_refresh <= 1'b1;
                            pending      <= pending;
                        end
                        if (!quantum_up)
                            q_cnt <= q_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (last_wr ? wr_ready : rd_ready)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    rd_en <= 1'b0;
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux: granted/releasing engine drives the bus, otherwise the arbiter.
    always_comb begin
        command = CMD_NOP;
        addr    = '0;
        bank    = '0;
        case (state)
            REFRESH:  command = CMD_AR;
            GRANT_RD: begin command = rd_command; addr = rd_addr; bank = rd_bank; end
            GRANT_WR: begin command = wr_command; addr = wr_addr; bank = wr_bank; end
            RELEASE: begin
                if (last_wr) begin
                    command = wr_command; addr = wr_addr; bank = wr_bank;
                end else begin
                    command = rd_command; addr = rd_addr; bank = rd_bank;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbiter
//   Directed testbench for sdram_arbiter built with REFRESH_PERIOD=20,
//   T_RFC=7, GRANT_QUANTUM=8. Cycle k is the k-th posedge after reset
//   release; outputs are sampled 1 ns after that edge.
// ---------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] AR  = 3'b001;
    localparam logic [2:0] S_IDLE = 3'd0, S_REF = 3'd1, S_RW = 3'd2,
                           S_GRD = 3'd3, S_GWR = 3'd4, S_REL = 3'd5;

    logic        clk, rst, init_done, rd_req, wr_req, rd_ready, wr_ready;
    logic        rd_en, wr_en, auto_refresh, refresh_err;
    logic [2:0]  rd_command, wr_command, command, state_dbg;
    logic [11:0] rd_addr, wr_addr, addr;
    logic [1:0]  rd_bank, wr_bank, bank;

    int total = 0;
    int bad   = 0;

    sdram_arbiter #(.REFRESH_PERIOD(20), .T_RFC(7), .GRANT_QUANTUM(8)) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .rd_req(rd_req), .wr_req(wr_req), .rd_en(rd_en), .wr_en(wr_en),
        .rd_ready(rd_ready), .wr_ready(wr_ready),
        .rd_command(rd_command), .wr_command(wr_command),
        .rd_addr(rd_addr), .wr_addr(wr_addr), .rd_bank(rd_bank), .wr_bank(wr_bank),
        .command(command), .addr(addr), .bank(bank),
        .auto_refresh(auto_refresh), .refresh_err(refresh_err), .state_dbg(state_dbg)
    );

    // ---- clock / reset ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic init);
        rst = 1'b0; init_done = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        rd_ready = 1'b1; wr_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b1; init_done = init;
    endtask

    task automatic set_buses();
        rd_command = 3'b010; rd_addr = 12'hA5C; rd_bank = 2'd3;
        wr_command = 3'b100; wr_addr = 12'h3C3; wr_bank = 2'd1;
    endtask

    // ---- tests ----
    task automatic test_reset();
        set_buses();
        rst = 1'b0; init_done = 1'b1; rd_req = 1'b1; wr_req = 1'b1;
        rd_ready = 1'b1; wr_ready = 1'b1;
        repeat (2) tick();
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%0b want=0", rd_en); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0b want=0", wr_en); end
        total++; if (auto_refresh !== 1'b0) begin bad++; $display("FAIL reset_auto_refresh got=%0b want=0", auto_refresh); end
        total++; if (refresh_err !== 1'b0) begin bad++; $display("FAIL reset_refresh_err got=%0b want=0", refresh_err); end
        total++; if (command !== NOP) begin bad++; $display("FAIL reset_command got=%b want=%b", command, NOP); end
        total++; if (addr !== 12'h000) begin bad++; $display("FAIL reset_addr got=%h want=000", addr); end
        total++; if (bank !== 2'd0) begin bad++; $display("FAIL reset_bank got=%0d want=0", bank); end
        total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, S_IDLE); end
    endtask

    task automatic test_initial_request();
        do_reset(1'b1);
        set_buses();
        rd_ready = 1'b0;
        repeat (4) tick();
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL init_req_pre_en got=%0b want=0", rd_en); end
        rd_req = 1'b1;
        tick();  // cycle 5 samples rd_req
        total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL init_req_rd_en got=%0b want=1", rd_en); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL init_req_wr_en got=%0b want=0", wr_en); end
        total++; if (command !== 3'b010) begin bad++; $display("FAIL init_req_command got=%b want=010", command); end
        total++; if (addr !== 12'hA5C) begin bad++; $display("FAIL init_req_addr got=%h want=a5c", addr); end
        total++; if (bank !== 2'd3) begin bad++; $display("FAIL init_req_bank got=%0d want=3", bank); end
        total++; if (state_dbg !== S_GRD) begin bad++; $display("FAIL init_req_state got=%0d want=%0d", state_dbg, S_GRD); end
        rd_req = 1'b0;
        tick();
        total++; if (state_dbg !== S_REL) begin bad++; $display("FAIL release_state got=%0d want=%0d", state_dbg, S_REL); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL release_rd_en got=%0b want=0", rd_en); end
        total++; if (command !== 3'b010) begin bad++; $display("FAIL release_mux got=%b want=010", command); end
        tick();
        total++; if (state_dbg !== S_REL) begin bad++; $display("FAIL release_stall got=%0d want=%0d", state_dbg, S_REL); end
        rd_ready = 1'b1;
        tick();
        total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL release_done got=%0d want=%0d", state_dbg, S_IDLE); end
        total++; if (command !== NOP) begin bad++; $display("FAIL release_done_cmd got=%b want=%b", command, NOP); end
    endtask

    task automatic test_round_robin();
        logic [2:0] es;
        do_reset(1'b1);
        set_buses();
        rd_req = 1'b1; wr_req = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k <= 8)       es = S_GRD;
            else if (k == 9)  es = S_REL;
            else if (k == 10) es = S_IDLE;
            else if (k <= 18) es = S_GWR;
            else if (k == 19) es = S_REL;
            else if (k == 20) es = S_IDLE;  // refresh due during RELEASE, now pending
            else if (k == 21) es = S_REF;
            else if (k <= 28) es = S_RW;
            else if (k == 29) es = S_IDLE;
            else              es = S_GRD;
            total++; if (state_dbg !== es) begin bad++; $display("FAIL rr_state k=%0d got=%0d want=%0d", k, state_dbg, es); end
            total++; if (rd_en !== (es == S_GRD)) begin bad++; $display("FAIL rr_rd_en k=%0d got=%0b want=%0b", k, rd_en, es == S_GRD); end
            total++; if (wr_en !== (es == S_GWR)) begin bad++; $display("FAIL rr_wr_en k=%0d got=%0b want=%0b", k, wr_en, es == S_GWR); end
            if (k == 19) begin
                total++; if (command !== 3'b100) begin bad++; $display("FAIL rr_release_mux got=%b want=100", command); end
            end
            if (k == 21) begin
                total++; if (command !== AR) begin bad++; $display("FAIL rr_pending_ar got=%b want=%b", command, AR); end
            end
        end
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_idle_refresh();
        logic [2:0] es;
        do_reset(1'b1);
        for (int k = 1; k <= 48; k++) begin
            tick();
            if (k == 20 || k == 40)                          es = S_REF;
            else if ((k >= 21 && k <= 27) || (k >= 41 && k <= 47)) es = S_RW;
            else                                             es = S_IDLE;
            total++; if (state_dbg !== es) begin bad++; $display("FAIL idle_ref_state k=%0d got=%0d want=%0d", k, state_dbg, es); end
            total++; if (command !== ((es == S_REF) ? AR : NOP)) begin bad++; $display("FAIL idle_ref_cmd k=%0d got=%b want=%b", k, command, (es == S_REF) ? AR : NOP); end
        end
    endtask

    task automatic test_refresh_in_grant();
        do_reset(1'b1);
        set_buses();
        rd_req = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL grant_ref_rd_en k=%0d got=%0b want=1", k, rd_en); end
            total++; if (auto_refresh !== (k == 20)) begin bad++; $display("FAIL grant_ref_pulse k=%0d got=%0b want=%0b", k, auto_refresh, k == 20); end
            total++; if (command !== 3'b010) begin bad++; $display("FAIL grant_ref_cmd k=%0d got=%b want=010", k, command); end
        end
        rd_req = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_missed_refresh();
        do_reset(1'b1);
        set_buses();
        rd_req = 1'b1; rd_ready = 1'b0;
        tick();          // cycle 1: grant
        rd_req = 1'b0;
        for (int k = 2; k <= 39; k++) tick();
        total++; if (refresh_err !== 1'b0) begin bad++; $display("FAIL missed_err_early got=%0b want=0", refresh_err); end
        total++; if (state_dbg !== S_REL) begin bad++; $display("FAIL missed_stall_state got=%0d want=%0d", state_dbg, S_REL); end
        tick();          // cycle 40: second expiry with refresh pending
        total++; if (refresh_err !== 1'b1) begin bad++; $display("FAIL missed_err_set got=%0b want=1", refresh_err); end
        rd_ready = 1'b1;
        tick();          // cycle 41: back to IDLE
        tick();          // cycle 42: pending refresh served
        total++; if (state_dbg !== S_REF) begin bad++; $display("FAIL missed_pending_ref got=%0d want=%0d", state_dbg, S_REF); end
        total++; if (refresh_err !== 1'b1) begin bad++; $display("FAIL missed_err_sticky got=%0b want=1", refresh_err); end
        rst = 1'b0;
        tick();
        total++; if (refresh_err !== 1'b0) begin bad++; $display("FAIL missed_err_clear got=%0b want=0", refresh_err); end
        rst = 1'b1;
    endtask

    task automatic test_mid_grant_reset();
        do_reset(1'b1);
        set_buses();
        wr_req = 1'b1;
        tick();
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL midrst_pre_wr_en got=%0b want=1", wr_en); end
        total++; if (command !== 3'b100) begin bad++; $display("FAIL midrst_pre_cmd got=%b want=100", command); end
        rst = 1'b0;
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL midrst_wr_en got=%0b want=0", wr_en); end
        total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL midrst_rd_en got=%0b want=0", rd_en); end
        total++; if (command !== NOP) begin bad++; $display("FAIL midrst_cmd got=%b want=%b", command, NOP); end
        total++; if (addr !== 12'h000) begin bad++; $display("FAIL midrst_addr got=%h want=000", addr); end
        total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL midrst_state got=%0d want=%0d", state_dbg, S_IDLE); end
        rst = 1'b1; wr_req = 1'b0;
    endtask

    task automatic test_no_init();
        do_reset(1'b0);
        set_buses();
        rd_req = 1'b1; wr_req = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            total++; if ((rd_en | wr_en) !== 1'b0) begin bad++; $display("FAIL noinit_en k=%0d got=%0b%0b want=00", k, rd_en, wr_en); end
            total++; if (command !== NOP) begin bad++; $display("FAIL noinit_cmd k=%0d got=%b want=%b", k, command, NOP); end
        end
        init_done = 1'b1;
        tick();
        total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL noinit_first_rd got=%0b want=1", rd_en); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL noinit_first_wr got=%0b want=0", wr_en); end
        rd_req = 1'b0; wr_req = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_initial_request();
        test_round_robin();
        test_idle_refresh();
        test_refresh_in_grant();
        test_missed_refresh();
        test_mid_grant_reset();
        test_no_init();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
